fsk_demod: RTL

Non-coherent FSK demodulator that recovers 9-bit frames from the single-bit FSK waveform produced by the team's FSK modulator. The modulator encodes a '1' as a toggle every clock and a '0' as a toggle every second clock, with 16 clocks per symbol and 9 symbols per frame sent LSB first. This block counts transitions per symbol window, slices each window to a bit, and assembles the bits into a parallel word with a valid strobe and an error flag. It sits on the receive side, clocked by the same clk as the modulator, with symbol alignment given by a `start` pulse.

---
 rtl/fsk_demod.sv | 103 ++++++++++
 1 files changed

// File: rtl/fsk_demod.sv
// Non-coherent FSK demodulator: counts datain transitions over each symbol
// window, slices the count to a bit and assembles NBITS-bit frames.
module fsk_demod #(
    parameter int SYM_LEN  = 16,
    parameter int NBITS    = 9,
    parameter int ONE_MIN  = 14,
    parameter int ZERO_MIN = 6,
    parameter int ZERO_MAX = 10,
    parameter int SLICE    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             datain,
    output logic [NBITS-1:0] dataout,
    output logic             valid,
    output logic             err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [3:0]       sym_cnt_q;
    logic [3:0]       bit_idx_q;
    logic [4:0]       acc_q;
    logic             datain_q;
    logic [NBITS-1:0] shift_q;
    logic             err_acc_q;
    logic [NBITS-1:0] dataout_q;
    logic             valid_q;
    logic             err_q;

    logic             toggle;
    logic [4:0]       acc_d;
    logic             end_win;
    logic             last_bit;
    logic             dec_bit;
    logic             sym_err;
    logic [NBITS-1:0] shift_d;

    // Window total includes the current sample so the decision covers all SYM_LEN samples.
    always_comb begin
        toggle   = datain ^ datain_q;
        acc_d    = acc_q + {4'b0000, toggle};
        end_win  = (sym_cnt_q == 4'(SYM_LEN - 1));
        last_bit = (bit_idx_q == 4'(NBITS - 1));
        dec_bit  = (acc_d >= 5'(SLICE));
        sym_err  = (acc_d < 5'(ZERO_MIN)) ||
                   ((acc_d > 5'(ZERO_MAX)) && (acc_d < 5'(ONE_MIN)));
        shift_d  = shift_q;
        shift_d[bit_idx_q] = dec_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sym_cnt_q <= '0;
            bit_idx_q <= '0;
            acc_q     <= '0;
            datain_q  <= 1'b0;
            shift_q   <= '0;
            err_acc_q <= 1'b0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            datain_q <= datain;
            valid_q  <= 1'b0;
            // A start realigns to a fresh frame and drops any partial one, even on a frame boundary.
            if (start) begin
                state_q   <= RUN;
                sym_cnt_q <= '0;
                bit_idx_q <= '0;
                acc_q     <= '0;
                err_acc_q <= 1'b0;
            end else if (state_q == RUN) begin
                if (!end_win) begin
                    acc_q     <= acc_d;
                    sym_cnt_q <= sym_cnt_q + 4'd1;
                end else begin
                    acc_q     <= '0;
                    sym_cnt_q <= '0;
                    shift_q   <= shift_d;
                    if (last_bit) begin
                        dataout_q <= shift_d;
                        err_q     <= err_acc_q | sym_err;
                        valid_q   <= 1'b1;
                        bit_idx_q <= '0;
                        err_acc_q <= 1'b0;
                    end else begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                        err_acc_q <= err_acc_q | sym_err;
                    end
                end
            end
        end
    end

    assign dataout = dataout_q;
    assign valid   = valid_q;
    assign err     = err_q;

endmodule
